// File: rtl/qpu_pkg.sv
// rtl/qpu_pkg.sv - gate opcodes and sequencer state encoding shared by QPU-side code
package qpu_pkg;

  typedef enum logic [1:0] {
    GATE_I   = 2'b00,
    GATE_X   = 2'b01,
    GATE_H   = 2'b10,
    GATE_RSV = 2'b11
  } gate_t;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } qseq_state_t;

  // The reserved opcode is never forwarded to the QPU; it degrades to identity.
  function automatic gate_t issue_op(input logic [1:0] op);
    return (op == GATE_RSV) ? GATE_I : gate_t'(op);
  endfunction

endpackage

// File: rtl/qseq_prog_mem.sv
// rtl/qseq_prog_mem.sv - DEPTH x 2 gate program storage, one write port, async read
module qseq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  // Not reset: a program survives a controller reset.
  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qpu_gate_sequencer.sv
// rtl/qpu_gate_sequencer.sv - program-driven gate issuer for the 1-qubit QPU
// Optional multi-pass looping is enabled with QSEQ_LOOP_EN.
module qpu_gate_sequencer
  import qpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
`ifdef QSEQ_LOOP_EN
  input  logic [7:0]    loop_cnt,
`endif
  output logic          busy,
  output logic          done,
  output logic          wr_err,
  output logic          illegal,
  output logic          qpu_reset,
  output logic [1:0]    qpu_gate,
  output logic [AW-1:0] pc
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  qseq_state_t   state, state_nxt;
  logic [AW:0]   len, len_nxt;
  logic [AW-1:0] pc_nxt;
  logic          ill_nxt;
  gate_t         gate_nxt;
  logic [1:0]    mem_rd;
  logic          mem_we;
  logic          in_run;

`ifdef QSEQ_LOOP_EN
  logic [7:0]    loops, loops_nxt;
`endif

  assign in_run = (state == INIT) || (state == RUN);
  assign mem_we = prog_we && !in_run;

  // Read at the upcoming pc so the registered gate lines up with pc.
  qseq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_nxt),
    .rdata (mem_rd)
  );

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    pc_nxt    = pc;
`ifdef QSEQ_LOOP_EN
    loops_nxt = loops;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = INIT;
          len_nxt   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
          pc_nxt    = '0;
`ifdef QSEQ_LOOP_EN
          loops_nxt = loop_cnt;
`endif
        end
      end
      INIT: begin
        pc_nxt    = '0;
        state_nxt = (len != '0) ? RUN : DONE;
      end
      RUN: begin
        if ({1'b0, pc} == len - LEN_ONE) begin
`ifdef QSEQ_LOOP_EN
          if (loops != 8'd0) begin
            pc_nxt    = '0;
            loops_nxt = loops - 8'd1;
          end else begin
            state_nxt = DONE;
          end
`else
          state_nxt = DONE;
`endif
        end else begin
          pc_nxt = pc + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Kept apart from the next-state logic: it depends on the memory read of pc_nxt.
  always_comb begin
    gate_nxt = GATE_I;
    ill_nxt  = illegal;
    if (state == IDLE && start) ill_nxt = 1'b0;
    if (state_nxt == RUN) begin
      gate_nxt = issue_op(mem_rd);
      if (mem_rd == GATE_RSV) ill_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      len       <= '0;
      pc        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
      illegal   <= 1'b0;
      qpu_reset <= 1'b0;
      qpu_gate  <= GATE_I;
`ifdef QSEQ_LOOP_EN
      loops     <= 8'd0;
`endif
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      pc        <= pc_nxt;
      busy      <= (state_nxt == INIT) || (state_nxt == RUN);
      done      <= (state_nxt == DONE);
      wr_err    <= prog_we && in_run;
      illegal   <= ill_nxt;
      qpu_reset <= (state_nxt == INIT);
      qpu_gate  <= gate_nxt;
`ifdef QSEQ_LOOP_EN
      loops     <= loops_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_qpu_gate_sequencer.sv
// tb/tb_qpu_gate_sequencer.sv - self-checking bench for qpu_gate_sequencer
// Exercises the QSEQ_LOOP_EN variant as well when that macro is defined.
module tb_qpu_gate_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [1:0]    prog_data;
  logic [AW:0]   prog_len;
  logic          start;
`ifdef QSEQ_LOOP_EN
  logic [7:0]    loop_cnt;
`endif
  logic          busy, done, wr_err, illegal, qpu_reset;
  logic [1:0]    qpu_gate;
  logic [AW-1:0] pc;

  always #5 clk = ~clk;

  qpu_gate_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
`ifdef QSEQ_LOOP_EN
    .loop_cnt  (loop_cnt),
`endif
    .busy      (busy),
    .done      (done),
    .wr_err    (wr_err),
    .illegal   (illegal),
    .qpu_reset (qpu_reset),
    .qpu_gate  (qpu_gate),
    .pc        (pc)
  );

  int         tests = 0;
  int         fails = 0;
  logic [1:0] tb_mem [DEPTH];
  real        a0 = 1.0;
  real        a1 = 0.0;
  logic [6:0] exp_q[$];
  int         pc_q[$];

  typedef struct {
    logic [7:0] prog;
    int         nw;
    int         len;
    int         lc;
    int         exp_done;
    real        q0;
    real        q1;
    logic       exp_ill;
  } vec_t;

`ifdef QSEQ_LOOP_EN
  localparam int NV = 5;
`else
  localparam int NV = 4;
`endif
  vec_t vecs [NV];

  // Ideal real-amplitude qubit fed by what the sequencer drives each cycle.
  task automatic step();
    real t;
    @(posedge clk);
    #1;
    if (qpu_reset) begin
      a0 = 1.0; a1 = 0.0;
    end else if (qpu_gate == 2'b01) begin
      t = a0; a0 = a1; a1 = t;
    end else if (qpu_gate == 2'b10) begin
      t = a0;
      a0 = (t + a1) / $sqrt(2.0);
      a1 = (t - a1) / $sqrt(2.0);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_real(input string name, input real act, input real exp);
    tests++;
    if ((act - exp > 1e-3) || (exp - act > 1e-3)) begin
      fails++;
      $display("FAIL %s: got %f, expected %f", name, act, exp);
    end
  endtask

  // Expected {busy,done,qpu_reset,gate,illegal,wr_err} from T+1 to the idle cycle after done.
  function automatic void build(input int plen, input int lc);
    int         len;
    int         passes;
    logic       ill;
    logic [1:0] op;
    len    = (plen > DEPTH) ? DEPTH : plen;
    passes = (len == 0) ? 1 : lc + 1;
    ill    = 1'b0;
    exp_q.delete();
    pc_q.delete();
    exp_q.push_back({1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0});
    pc_q.push_back(0);
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < len; k++) begin
        op = tb_mem[k];
        if (op == 2'b11) begin
          ill = 1'b1;
          op  = 2'b00;
        end
        exp_q.push_back({1'b1, 1'b0, 1'b0, op, ill, 1'b0});
        pc_q.push_back(k);
      end
    end
    exp_q.push_back({1'b0, 1'b1, 1'b0, 2'b00, ill, 1'b0});
    pc_q.push_back(-1);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 2'b00, ill, 1'b0});
    pc_q.push_back(-1);
  endfunction

  task automatic run_check(input int plen, input int lc, output int done_at);
    build(plen, lc);
    prog_len = (AW+1)'(plen);
`ifdef QSEQ_LOOP_EN
    loop_cnt = 8'(lc);
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    done_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (done && done_at < 0) done_at = i + 1;
      check($sformatf("cyc%0d_len%0d", i + 1, plen),
            int'({busy, done, qpu_reset, qpu_gate, illegal, wr_err}), int'(exp_q[i]));
      if (pc_q[i] >= 0) check($sformatf("pc_cyc%0d", i + 1), int'(pc), pc_q[i]);
      if (i < exp_q.size() - 1) step();
    end
  endtask

  task automatic write_prog(input int addr, input logic [1:0] data);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = data;
    step();
    prog_we = 1'b0;
    tb_mem[addr] = data;
  endtask

  initial begin
    int         d;
    int         n;
    int         lc;
    logic       saw;
    logic [7:0] p;

    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0;
`ifdef QSEQ_LOOP_EN
    loop_cnt = '0;
`endif

    vecs[0] = '{8'b00_00_00_01, 1, 1, 0, 3, 0.0, 1.0, 1'b0};
    vecs[1] = '{8'b00_00_10_10, 2, 2, 0, 4, 1.0, 0.0, 1'b0};
    vecs[2] = '{8'b00_01_11_01, 3, 3, 0, 5, 1.0, 0.0, 1'b1};
    vecs[3] = '{8'b00_00_00_00, 0, 0, 0, 2, 1.0, 0.0, 1'b0};
`ifdef QSEQ_LOOP_EN
    vecs[4] = '{8'b00_00_00_01, 1, 1, 2, 5, 0.0, 1.0, 1'b0};
`endif

    step();
    step();
    check("rst_outs", int'({busy, done, wr_err, illegal, qpu_reset, qpu_gate}), 0);
    check("rst_pc", int'(pc), 0);
    reset = 1'b1;
    step();
    check("idle_outs", int'({busy, done, wr_err, illegal, qpu_reset, qpu_gate}), 0);

    for (int i = 0; i < NV; i++) begin
      p = vecs[i].prog;
      for (int k = 0; k < vecs[i].nw; k++) write_prog(k, p[2*k +: 2]);
      run_check(vecs[i].len, vecs[i].lc, d);
      check($sformatf("vec%0d_done_at", i), d, vecs[i].exp_done);
      check_real($sformatf("vec%0d_q0", i), a0, vecs[i].q0);
      check_real($sformatf("vec%0d_q1", i), a1, vecs[i].q1);
      check($sformatf("vec%0d_illegal", i), int'(illegal), int'(vecs[i].exp_ill));
    end

    // Write and start during RUN are dropped; start in DONE is dropped.
    for (int k = 0; k < 4; k++) write_prog(k, 2'b01);
    prog_len = 5'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    check("wr_init_busy", int'(busy), 1);
    step();
    prog_we = 1'b1; prog_addr = '0; prog_data = 2'b10; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    check("wr_err_pulse", int'(wr_err), 1);
    step();
    check("wr_err_clear", int'(wr_err), 0);
    n = 4;
    while (!done && n < 12) begin
      step();
      n++;
    end
    check("wr_run_len", n, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_ign", int'(busy), 0);
    step();
    check("done_start_ign2", int'(busy), 0);
    run_check(4, 0, d);
    check("mem_unchanged_done_at", d, 6);

    // Length clamp at DEPTH.
    for (int k = 0; k < DEPTH; k++) write_prog(k, 2'($urandom_range(0, 2)));
    run_check(DEPTH + 3, 0, d);
    check("clamp_done_at", d, DEPTH + 2);

    // Reset mid-run aborts silently.
    prog_len = 5'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("abort_outs", int'({busy, done, wr_err, illegal, qpu_reset, qpu_gate}), 0);
    check("abort_pc", int'(pc), 0);
    reset = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      step();
      if (done || busy) saw = 1'b1;
    end
    check("abort_no_done", int'(saw), 0);

    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < DEPTH; k++) write_prog(k, 2'($urandom_range(0, 3)));
`ifdef QSEQ_LOOP_EN
      lc = int'($urandom_range(0, 2));
`else
      lc = 0;
`endif
      run_check(int'($urandom_range(0, 2 * DEPTH - 1)), lc, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
